// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel front end: pixel widths,
// luma weights and the frame-reader FSM encoding.
package sobel_pkg;

   localparam int unsigned RGB_W      = 24;
   localparam int unsigned GRAY_W     = 8;
   localparam int unsigned ACC_W      = 16;
   localparam int unsigned LUMA_SHIFT = 8;

   localparam logic [ACC_W-1:0] LUMA_R = 16'd77;
   localparam logic [ACC_W-1:0] LUMA_G = 16'd150;
   localparam logic [ACC_W-1:0] LUMA_B = 16'd29;

   localparam logic [1:0] DRAIN_LEN = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sobel_rgb2gray.sv
// Combinational RGB888 to 8-bit luma: (77R + 150G + 29B) >> 8, truncated.
module sobel_rgb2gray
   import sobel_pkg::*;
(
   input  logic [RGB_W-1:0]  rgb_i,
   output logic [GRAY_W-1:0] gray_o
);

   logic [ACC_W-1:0] acc;

   // Worst case 255*256 = 65280 fits the 16-bit accumulator without wrap.
   always_comb begin
      acc = LUMA_R * ACC_W'(rgb_i[23:16])
          + LUMA_G * ACC_W'(rgb_i[15:8])
          + LUMA_B * ACC_W'(rgb_i[7:0]);
      gray_o = GRAY_W'(acc >> LUMA_SHIFT);
   end

endmodule

// File: rtl/sobel_pixel_streamer.sv
// Frame reader: walks the frame RAM in raster order and emits a gapless
// grayscale pixel stream with a per-frame completion pulse.
module sobel_pixel_streamer
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W  = 6,
   parameter int unsigned IMG_H  = 6,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [23:0]       mem_data_i,
   output logic [7:0]        grayscale_o,
   output logic              done_o,
   output logic              busy_o,
   output logic              frame_done_o
);

   localparam int unsigned      NPIX      = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic                en_nxt;
   logic [1:0]          drain_cnt, drain_nxt;
   logic                en_d1;
   logic [GRAY_W-1:0]   gray_w;

   sobel_rgb2gray u_rgb2gray (
      .rgb_i  (mem_data_i),
      .gray_o (gray_w)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         mem_en_o   <= 1'b0;
         mem_addr_o <= '0;
         drain_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         mem_en_o   <= en_nxt;
         mem_addr_o <= addr_nxt;
         drain_cnt  <= drain_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      en_nxt    = mem_en_o;
      addr_nxt  = mem_addr_o;
      drain_nxt = drain_cnt;
      unique case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt = ST_READ;
               en_nxt    = 1'b1;
               addr_nxt  = '0;
            end
         end
         ST_READ: begin
            if (mem_addr_o == LAST_ADDR) begin
               state_nxt = ST_DRAIN;
               en_nxt    = 1'b0;
               drain_nxt = DRAIN_LEN;
            end else begin
               addr_nxt = mem_addr_o + 1'b1;
            end
         end
         ST_DRAIN: begin
            drain_nxt = drain_cnt - 1'b1;
            if (drain_cnt == 2'd1) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            // The DONE cycle doubles as a start-sampling slot so the frame
            // period stays at N+3 with start held high.
            if (start_i) begin
               state_nxt = ST_READ;
               en_nxt    = 1'b1;
               addr_nxt  = '0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy_o       = (state != ST_IDLE);
   assign frame_done_o = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_d1       <= 1'b0;
         done_o      <= 1'b0;
         grayscale_o <= '0;
      end else begin
         en_d1       <= mem_en_o;
         done_o      <= en_d1;
         grayscale_o <= en_d1 ? gray_w : '0;
      end
   end

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Scoreboard bench for sobel_pixel_streamer: 6x6 instance plus a 1x1 instance.
module tb_sobel_pixel_streamer;

   localparam int N = 36;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mem_en;
   logic [15:0] mem_addr;
   logic [23:0] mem_data = '0;
   logic [7:0]  gray;
   logic        done, busy, fd;

   logic        start1 = 1'b0;
   logic        mem_en1;
   logic [15:0] mem_addr1;
   logic [23:0] mem_data1 = '0;
   logic [23:0] data1 = {8'd10, 8'd20, 8'd30};
   logic [7:0]  gray1;
   logic        done1, busy1, fd1;

   logic [23:0] ram [0:N-1];
   logic [7:0]  exp_q [$];

   int total = 0;
   int bad = 0;
   int fd_count = 0;
   int frames_exp = 0;
   int run_len = 0;
   int gap = 0;
   int addr_exp = 0;
   logic prev_done = 1'b0;
   logic gap_chk = 1'b0;

   always #5 clk = ~clk;

   sobel_pixel_streamer #(.IMG_W(6), .IMG_H(6), .ADDR_W(16)) u_dut (
      .clk(clk), .rst(rst), .start_i(start), .mem_en_o(mem_en),
      .mem_addr_o(mem_addr), .mem_data_i(mem_data), .grayscale_o(gray),
      .done_o(done), .busy_o(busy), .frame_done_o(fd)
   );

   sobel_pixel_streamer #(.IMG_W(1), .IMG_H(1), .ADDR_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start1), .mem_en_o(mem_en1),
      .mem_addr_o(mem_addr1), .mem_data_i(mem_data1), .grayscale_o(gray1),
      .done_o(done1), .busy_o(busy1), .frame_done_o(fd1)
   );

   always @(posedge clk) begin
      if (mem_en && int'(mem_addr) < N) mem_data <= ram[int'(mem_addr)];
      if (mem_en1) mem_data1 <= data1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every valid pixel.
   always @(negedge clk) begin
      if (!rst) begin
         prev_done = 1'b0;
         gap = 0;
         addr_exp = 0;
      end else begin
         if (done) begin
            if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
            else chk("gray", int'(gray), int'(exp_q.pop_front()));
            if (!prev_done && gap_chk) chk("frame_gap", gap, 3);
            run_len = prev_done ? run_len + 1 : 1;
            gap = 0;
         end else begin
            chk("gray_idle_zero", int'(gray), 0);
            gap++;
         end
         if (mem_en) begin
            chk("addr", int'(mem_addr), addr_exp);
            addr_exp++;
         end else begin
            addr_exp = 0;
         end
         if (fd) begin
            chk("run_len", run_len, N);
            chk("fd_done_low", int'(done), 0);
            fd_count++;
         end
         prev_done = done;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic push_ramp();
      for (int i = 0; i < N; i++) exp_q.push_back(8'(i + 1));
   endtask

   task automatic load_ramp();
      for (int i = 0; i < N; i++) ram[i] = {8'(i + 1), 8'(i + 1), 8'(i + 1)};
   endtask

   task automatic wait_fd();
      int cnt;
      cnt = 0;
      while (!fd && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (!fd) chk("fd_timeout", 0, 1);
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      load_ramp();
      #12;
      chk("rst_en", int'(mem_en), 0);
      chk("rst_addr", int'(mem_addr), 0);
      chk("rst_gray", int'(gray), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fd", int'(fd), 0);
      step(2);
      rst = 1'b1;
      step(2);

      // Ramp frame with edge-accurate timing checks
      push_ramp(); frames_exp++;
      pulse_start();
      chk("k_en", int'(mem_en), 1);
      chk("k_addr", int'(mem_addr), 0);
      chk("k_busy", int'(busy), 1);
      chk("k_done", int'(done), 0);
      step(1); chk("k1_done", int'(done), 0);
      step(1); chk("k2_done", int'(done), 1);
      step(N - 1);
      chk("kN1_done", int'(done), 1);
      chk("kN1_fd", int'(fd), 0);
      step(1);
      chk("kN2_fd", int'(fd), 1);
      chk("kN2_done", int'(done), 0);
      step(1); chk("kN3_busy", int'(busy), 0);
      step(2);

      // Color weights
      load_ramp();
      ram[0] = {8'd255, 8'd0, 8'd0};
      ram[1] = {8'd0, 8'd255, 8'd0};
      ram[2] = {8'd0, 8'd0, 8'd255};
      ram[3] = {8'd255, 8'd255, 8'd255};
      ram[4] = {8'd100, 8'd100, 8'd100};
      exp_q.push_back(8'd76);
      exp_q.push_back(8'd149);
      exp_q.push_back(8'd28);
      exp_q.push_back(8'd255);
      exp_q.push_back(8'd100);
      for (int i = 5; i < N; i++) exp_q.push_back(8'(i + 1));
      frames_exp++;
      pulse_start();
      wait_fd();
      step(2);

      // Start while busy is ignored; start in the DONE slot launches
      load_ramp();
      push_ramp(); frames_exp++;
      pulse_start();
      step(9); start = 1'b1;
      step(1); start = 1'b0;
      step(27); chk("busy_kN1_fd", int'(fd), 0);
      step(1); chk("busy_kN2_fd", int'(fd), 1);
      push_ramp(); frames_exp++;
      start = 1'b1;
      step(1); start = 1'b0;
      chk("restart_en", int'(mem_en), 1);
      chk("restart_addr", int'(mem_addr), 0);
      chk("restart_busy", int'(busy), 1);
      wait_fd();
      step(2);

      // Mid-frame reset
      push_ramp();
      pulse_start();
      step(14);
      @(posedge clk); #2 rst = 1'b0;
      #1;
      chk("mrst_done", int'(done), 0);
      chk("mrst_gray", int'(gray), 0);
      chk("mrst_en", int'(mem_en), 0);
      chk("mrst_addr", int'(mem_addr), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_fd", int'(fd), 0);
      exp_q.delete();
      step(2); rst = 1'b1;
      step(1);
      push_ramp(); frames_exp++;
      pulse_start();
      chk("mrst_restart_addr", int'(mem_addr), 0);
      wait_fd();
      step(2);

      // Back-to-back frames with start held high
      push_ramp(); push_ramp(); push_ramp(); frames_exp += 3;
      @(negedge clk); start = 1'b1;
      step(1);
      step(3); gap_chk = 1'b1;
      step(75);
      chk("b2b_third_en", int'(mem_en), 1);
      chk("b2b_third_addr", int'(mem_addr), 0);
      start = 1'b0;
      wait_fd();
      gap_chk = 1'b0;
      step(3);

      // Degenerate 1x1 frame: (770+3000+870)>>8 = 18
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      chk("one_en", int'(mem_en1), 1);
      chk("one_busy", int'(busy1), 1);
      step(1); chk("one_k1_done", int'(done1), 0);
      step(1);
      chk("one_k2_done", int'(done1), 1);
      chk("one_k2_gray", int'(gray1), 18);
      chk("one_k2_fd", int'(fd1), 0);
      step(1);
      chk("one_k3_fd", int'(fd1), 1);
      chk("one_k3_done", int'(done1), 0);
      step(1); chk("one_k4_busy", int'(busy1), 0);

      step(2);
      chk("frame_count", fd_count, frames_exp);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
